// File: rtl/codec_buffer.sv
`default_nettype none
// ============================================================================
// Module      : codec_buffer
// Description : Ping-pong sample buffer between the byte-stream loader and
//               the audio codec. Two banks of 2^BUFFER_ADDR_BITS bytes; the
//               loader fills one bank while the codec plays the other, and
//               the codec hands each bank back with a one-cycle empty pulse.
//               Optional feature macro: CODEC_BUFFER_ZERO_PAD_EN
//               (when defined, a short final bank is zero-padded to full
//               length instead of being completed early).
// Revision    : 1.0 - initial release
// ============================================================================
module codec_buffer #(
    parameter int BUFFER_ADDR_BITS = 9
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  wr_data_i,
    input  logic                        wr_valid_i,
    input  logic                        wr_last_i,
    output logic                        wr_ready_o,
    output logic                        wr_bank_o,
    input  logic [BUFFER_ADDR_BITS-1:0] codec_buffer_addr_i,
    input  logic                        codec_buffer_sel_i,
    output logic [7:0]                  codec_buffer_data_o,
    output logic                        codec_buffer_filled_o,
    input  logic                        codec_buffer_empty_i
);

    localparam int                    c_BANK_BYTES = 1 << BUFFER_ADDR_BITS;
    localparam int                    c_RAM_BYTES  = 2 * c_BANK_BYTES;
    localparam logic [BUFFER_ADDR_BITS-1:0] c_LAST_ADDR = '1;

`ifdef CODEC_BUFFER_ZERO_PAD_EN
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_PAD  = 1'b1
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_FILL = 1'b0
    } state_t;
`endif

    // Storage: index is {bank, addr}
    logic [7:0]                  r_mem [c_RAM_BYTES];

    // Writer and bank state
    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [1:0]                  r_full;
    logic                        r_wr_bank;
    logic [BUFFER_ADDR_BITS-1:0] r_wr_addr;
    logic [7:0]                  r_rd_data;

    // Combinational control
    logic                        w_ready;
    logic                        w_accept;
    logic                        w_at_end;
    logic                        w_mem_we;
    logic [7:0]                  w_mem_wdata;
    logic [BUFFER_ADDR_BITS:0]   w_mem_waddr;
    logic                        w_complete;
    logic                        w_addr_inc;
    logic [1:0]                  w_full_set;
    logic [1:0]                  w_full_clr;

    // The loader may write only while filling and only into a bank it owns;
    // deliberately independent of wr_valid_i so ready never loops back.
    assign w_ready     = (r_state == ST_FILL) && !r_full[r_wr_bank];
    assign w_accept    = wr_valid_i && w_ready;
    assign w_at_end    = (r_wr_addr == c_LAST_ADDR);
    assign w_mem_waddr = {r_wr_bank, r_wr_addr};

    // Next-state, write strobe and bank-completion decode
    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_mem_wdata = wr_data_i;
        w_complete  = 1'b0;
        w_addr_inc  = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_accept) begin
                    w_mem_we = 1'b1;
                    if (w_at_end) begin
                        w_complete = 1'b1;
                    end else if (wr_last_i) begin
`ifdef CODEC_BUFFER_ZERO_PAD_EN
                        // Short stream: zero the rest of the bank first
                        w_addr_inc  = 1'b1;
                        w_state_nxt = ST_PAD;
`else
                        // Short stream: hand over now, tail keeps stale bytes
                        w_complete  = 1'b1;
`endif
                    end else begin
                        w_addr_inc = 1'b1;
                    end
                end
            end
`ifdef CODEC_BUFFER_ZERO_PAD_EN
            ST_PAD: begin
                w_mem_we    = 1'b1;
                w_mem_wdata = 8'h00;
                if (w_at_end) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_FILL;
                end else begin
                    w_addr_inc = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
    end

    // Per-bank set/clear requests; a completing bank is never full, so a
    // release aimed at it is a no-op and set takes precedence below.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_full_set[b] = w_complete && (r_wr_bank == 1'(b));
        assign w_full_clr[b] = codec_buffer_empty_i && (codec_buffer_sel_i == 1'(b));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bank ownership flags: completion marks full, codec release clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 2'b00;
        end else begin
            r_full <= (r_full & ~w_full_clr) | w_full_set;
        end
    end

    // Write pointer: advance per byte, wrap and swap bank on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_wr_addr <= '0;
        end else if (w_complete) begin
            r_wr_bank <= ~r_wr_bank;
            r_wr_addr <= '0;
        end else if (w_addr_inc) begin
            r_wr_addr <= r_wr_addr + 1'b1;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Codec read port: registered every cycle, old data on collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= r_mem[{codec_buffer_sel_i, codec_buffer_addr_i}];
        end
    end

    assign wr_ready_o            = w_ready;
    assign wr_bank_o             = r_wr_bank;
    assign codec_buffer_data_o   = r_rd_data;
    assign codec_buffer_filled_o = r_full[codec_buffer_sel_i];

endmodule
`default_nettype wire
